exec_monitor: RTL and testbench

EXEC_MONITOR -- requirements
Module: exec_monitor

---
 rtl/exec_monitor.sv | 163 ++++++++++++++++
 tb/tb_exec_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_monitor.sv
// exec_monitor: watches a processor's PC stream, counts activity and latches a sticky halt
// on HALT_PC, stall loops or (with EXEC_MON_JDETECT_EN defined) a decoded jump-to-self.
module exec_monitor #(
    parameter logic [31:0] HALT_PC     = 32'h0000_003C,
    parameter int unsigned LOOP_THRESH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        clear,
    output logic        halted,
    output logic [1:0]  halt_reason,
    output logic [31:0] halt_pc,
    output logic [31:0] cycle_count,
    output logic [15:0] regwr_count,
    output logic [15:0] memwr_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_SUSPECT = 2'b10,
        S_HALTED  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        R_NONE      = 2'b00,
        R_HALT_PC   = 2'b01,
        R_JUMP_SELF = 2'b10,
        R_STALL     = 2'b11
    } reason_e;

    localparam logic [7:0] REPEAT_LIMIT = 8'(LOOP_THRESH - 1);

    state_e      state_q, state_d;
    reason_e     reason_q, reason_d;
    logic [31:0] prev_pc_q, prev_pc_d;
    logic [7:0]  repeat_q, repeat_d;
    logic [31:0] cycle_q, cycle_d;
    logic [15:0] regwr_q, regwr_d;
    logic [15:0] memwr_q, memwr_d;
    logic        halted_q, halted_d;
    logic [31:0] halt_pc_q, halt_pc_d;

    logic        jump_self;
    logic        pc_same;
    logic [7:0]  repeat_next;

`ifdef EXEC_MON_JDETECT_EN
    // J-type opcode whose absolute target equals the fetching PC
    assign jump_self = (instruction[31:26] == 6'b000010) &&
                       ({pc[31:28], instruction[25:0], 2'b00} == pc);
`else
    logic unused_instruction;
    assign unused_instruction = ^instruction;
    assign jump_self          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        reason_d    = reason_q;
        prev_pc_d   = prev_pc_q;
        repeat_d    = repeat_q;
        cycle_d     = cycle_q;
        regwr_d     = regwr_q;
        memwr_d     = memwr_q;
        halted_d    = halted_q;
        halt_pc_d   = halt_pc_q;
        pc_same     = (pc == prev_pc_q);
        repeat_next = (state_q == S_RUN) ? 8'd1 : repeat_q + 8'd1;

        if (clear) begin
            state_d   = S_IDLE;
            reason_d  = R_NONE;
            prev_pc_d = '0;
            repeat_d  = '0;
            cycle_d   = '0;
            regwr_d   = '0;
            memwr_d   = '0;
            halted_d  = 1'b0;
            halt_pc_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    prev_pc_d = pc;
                    state_d   = S_RUN;
                end
                S_RUN, S_SUSPECT: begin
                    cycle_d   = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
                    if (reg_write && regwr_q != '1) regwr_d = regwr_q + 16'd1;
                    if (mem_write && memwr_q != '1) memwr_d = memwr_q + 16'd1;
                    prev_pc_d = pc;

                    // The halting edge is still counted; priority HALT_PC > jump-to-self > stall
                    if (pc == HALT_PC) begin
                        state_d   = S_HALTED;
                        reason_d  = R_HALT_PC;
                        halted_d  = 1'b1;
                        halt_pc_d = pc;
                    end else if (jump_self) begin
                        state_d   = S_HALTED;
                        reason_d  = R_JUMP_SELF;
                        halted_d  = 1'b1;
                        halt_pc_d = pc;
                    end else if (pc_same && repeat_next >= REPEAT_LIMIT) begin
                        state_d   = S_HALTED;
                        reason_d  = R_STALL;
                        halted_d  = 1'b1;
                        halt_pc_d = pc;
                        repeat_d  = repeat_next;
                    end else if (pc_same) begin
                        state_d  = S_SUSPECT;
                        repeat_d = repeat_next;
                    end else begin
                        state_d  = S_RUN;
                        repeat_d = '0;
                    end
                end
                S_HALTED: begin
                    state_d = S_HALTED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            reason_q  <= R_NONE;
            prev_pc_q <= '0;
            repeat_q  <= '0;
            cycle_q   <= '0;
            regwr_q   <= '0;
            memwr_q   <= '0;
            halted_q  <= 1'b0;
            halt_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            reason_q  <= reason_d;
            prev_pc_q <= prev_pc_d;
            repeat_q  <= repeat_d;
            cycle_q   <= cycle_d;
            regwr_q   <= regwr_d;
            memwr_q   <= memwr_d;
            halted_q  <= halted_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    assign halted      = halted_q;
    assign halt_reason = reason_q;
    assign halt_pc     = halt_pc_q;
    assign cycle_count = cycle_q;
    assign regwr_count = regwr_q;
    assign memwr_count = memwr_q;

endmodule

// File: tb/tb_exec_monitor.sv
// Self-checking bench for exec_monitor: run-length based reference model compared every cycle,
// plus directed literal expectations. Build with EXEC_MON_JDETECT_EN to cover jump-to-self.
module tb_exec_monitor;

    localparam logic [31:0] HALT_PC     = 32'h0000_003C;
    localparam int unsigned LOOP_THRESH = 4;
`ifdef EXEC_MON_JDETECT_EN
    localparam bit JD = 1'b1;
`else
    localparam bit JD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        reg_write;
    logic        mem_write;
    logic        clear;
    logic        halted;
    logic [1:0]  halt_reason;
    logic [31:0] halt_pc;
    logic [31:0] cycle_count;
    logic [15:0] regwr_count;
    logic [15:0] memwr_count;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: phase 0 = waiting for first edge, 1 = monitoring, 2 = halted
    int          m_phase;
    logic [31:0] m_last_pc;
    int          m_runlen;
    logic [31:0] m_cycle;
    logic [15:0] m_rw;
    logic [15:0] m_mw;
    logic        m_halted;
    logic [1:0]  m_reason;
    logic [31:0] m_hpc;

    exec_monitor #(
        .HALT_PC     (HALT_PC),
        .LOOP_THRESH (LOOP_THRESH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .clear       (clear),
        .halted      (halted),
        .halt_reason (halt_reason),
        .halt_pc     (halt_pc),
        .cycle_count (cycle_count),
        .regwr_count (regwr_count),
        .memwr_count (memwr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_last_pc = '0;
        m_runlen  = 0;
        m_cycle   = '0;
        m_rw      = '0;
        m_mw      = '0;
        m_halted  = 1'b0;
        m_reason  = 2'd0;
        m_hpc     = '0;
    endtask

    task automatic model_edge();
        logic [1:0] r;
        if (!reset || clear) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_last_pc = pc;
            m_runlen  = 1;
            m_phase   = 1;
        end else if (m_phase == 1) begin
            if (m_cycle != 32'hFFFF_FFFF) m_cycle++;
            if (reg_write && m_rw != 16'hFFFF) m_rw++;
            if (mem_write && m_mw != 16'hFFFF) m_mw++;
            m_runlen  = (pc == m_last_pc) ? m_runlen + 1 : 1;
            m_last_pc = pc;
            r = 2'd0;
            if (pc == HALT_PC) r = 2'd1;
            else if (JD && instruction[31:26] == 6'b000010 &&
                     {pc[31:28], instruction[25:0], 2'b00} == pc) r = 2'd2;
            else if (m_runlen >= int'(LOOP_THRESH)) r = 2'd3;
            if (r != 2'd0) begin
                m_phase  = 2;
                m_halted = 1'b1;
                m_reason = r;
                m_hpc    = pc;
            end
        end
    endtask

    task automatic compare_all();
        chk("halted",      {31'd0, halted},      {31'd0, m_halted});
        chk("halt_reason", {30'd0, halt_reason}, {30'd0, m_reason});
        chk("halt_pc",     halt_pc,              m_hpc);
        chk("cycle_count", cycle_count,          m_cycle);
        chk("regwr_count", {16'd0, regwr_count}, {16'd0, m_rw});
        chk("memwr_count", {16'd0, memwr_count}, {16'd0, m_mw});
    endtask

    task automatic cyc(input logic [31:0] p, input logic [31:0] ins,
                       input logic rw, input logic mw, input logic cl);
        pc          = p;
        instruction = ins;
        reg_write   = rw;
        mem_write   = mw;
        clear       = cl;
        @(posedge clk);
        model_edge();
        #2;
        compare_all();
        @(negedge clk);
    endtask

    task automatic step(input logic [31:0] p);
        cyc(p, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic midcycle_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_rst_halted", {31'd0, halted}, 32'd0);
        chk("async_rst_cycle",  cycle_count,     32'd0);
        chk("async_rst_hpc",    halt_pc,         32'd0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        pc          = '0;
        instruction = '0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        clear       = 1'b0;
        model_reset();

        // Reset state
        cyc(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        cyc(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_cycle",  cycle_count,     32'd0);
        chk("reset_regwr",  {16'd0, regwr_count}, 32'd0);
        reset = 1'b1;

        // PC stepping to HALT_PC with 5 register writes and 2 memory writes
        step(32'h0);
        for (int unsigned k = 0; k < 16; k++)
            cyc(32'(k * 4), 32'h0, k < 5, k < 2, 1'b0);
        chk("halt_pc_hit_halted", {31'd0, halted},      32'd1);
        chk("halt_pc_hit_reason", {30'd0, halt_reason}, 32'd1);
        chk("halt_pc_hit_pc",     halt_pc,              32'h3C);
        chk("halt_pc_hit_cycles", cycle_count,          32'd16);
        chk("halt_regwr",         {16'd0, regwr_count}, 32'd5);
        chk("halt_memwr",         {16'd0, memwr_count}, 32'd2);
        for (int i = 0; i < 10; i++)
            cyc($urandom, $urandom, 1'b1, 1'b1, 1'b0);
        chk("frozen_regwr",  {16'd0, regwr_count}, 32'd5);
        chk("frozen_memwr",  {16'd0, memwr_count}, 32'd2);
        chk("frozen_cycles", cycle_count,          32'd16);
        chk("frozen_hpc",    halt_pc,              32'h3C);

        // Clear in HALTED returns to IDLE: next edge is not counted
        cyc(32'h3C, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("clear_halted", {31'd0, halted},      32'd0);
        chk("clear_reason", {30'd0, halt_reason}, 32'd0);
        chk("clear_cycles", cycle_count,          32'd0);
        step(32'h18);
        chk("idle_edge_uncounted", cycle_count, 32'd0);
        step(32'h1C);
        chk("first_run_edge", cycle_count, 32'd1);

        // Stall loop at 0x20
        step(32'h20);
        step(32'h20);
        step(32'h20);
        chk("stall_3rd_not_halted", {31'd0, halted}, 32'd0);
        step(32'h20);
        chk("stall_halted", {31'd0, halted},      32'd1);
        chk("stall_reason", {30'd0, halt_reason}, 32'd3);
        chk("stall_hpc",    halt_pc,              32'h20);
        chk("stall_cycles", cycle_count,          32'd5);

        // Reset from HALTED, then reset again while in SUSPECT
        midcycle_reset();
        step(32'h40);
        step(32'h44);
        step(32'h44);
        chk("suspect_cycles", cycle_count, 32'd2);
        midcycle_reset();
        step(32'h50);
        chk("post_rst_idle_cycles", cycle_count, 32'd0);
        step(32'h54);
        chk("post_rst_run_cycles", cycle_count, 32'd1);

        // Jump-to-self at 0x10
        cyc(32'h10, 32'h0800_0004, 1'b0, 1'b0, 1'b0);
`ifdef EXEC_MON_JDETECT_EN
        chk("jself_halted", {31'd0, halted},      32'd1);
        chk("jself_reason", {30'd0, halt_reason}, 32'd2);
        chk("jself_hpc",    halt_pc,              32'h10);
`else
        chk("jself_not_decoded", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 3; i++)
            cyc(32'h10, 32'h0800_0004, 1'b0, 1'b0, 1'b0);
        chk("jself_stall_reason", {30'd0, halt_reason}, 32'd3);
        chk("jself_stall_hpc",    halt_pc,              32'h10);
        chk("jself_stall_cycles", cycle_count,          32'd5);
`endif

        // HALT_PC wins over a coincident jump-to-self; HALT_PC in IDLE does not halt
        cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(32'h3C, 32'h0800_000F, 1'b0, 1'b0, 1'b0);
        chk("idle_halt_pc_ignored", {31'd0, halted}, 32'd0);
        cyc(32'h3C, 32'h0800_000F, 1'b0, 1'b0, 1'b0);
        chk("prio_reason", {30'd0, halt_reason}, 32'd1);
        chk("prio_cycles", cycle_count,          32'd1);

        // Interrupted repeats never reach the threshold
        cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h7C);
        for (int i = 0; i < 3; i++) step(32'h80);
        for (int i = 0; i < 3; i++) step(32'h84);
        chk("broken_run_not_halted", {31'd0, halted}, 32'd0);
        step(32'h84);
        chk("run4_reason", {30'd0, halt_reason}, 32'd3);
        chk("run4_hpc",    halt_pc,              32'h84);
        chk("run4_cycles", cycle_count,          32'd7);

        // Clear overrides a HALT_PC hit in RUN
        cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h0);
        step(32'h4);
        cyc(32'h3C, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("clear_over_halt", {31'd0, halted}, 32'd0);
        chk("clear_over_cnt",  cycle_count,     32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
